pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central sequencer for the 5-stage pipeline (pc, if/id, id/ex, ex/mem, mem/wb).
//  Merges stall requests from fetch, decode and multi-cycle execute ops into one stall vector.
//  Sequences exception/redirect flushes and counts stalled cycles for performance monitoring.
//  Sits beside the datapath in openmips; every pipeline register consumes stall_o/flush_o.
// PARAMETERS
//  CNT_W    6   width of the multi-cycle execute length and down-counter
//  PERF_W  32   width of the saturating stall-cycle counter
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       asynchronous reset, active high
//  stallreq_if    in   1       instruction ROM not ready this cycle
//  stallreq_id    in   1       load-use hazard detected in decode (combinational, same cycle)
//  ex_start       in   1       pulse: multi-cycle execute op enters ex this cycle
//  ex_len         in   CNT_W   cycles the op must hold ex (0 treated as 1)
//  flush_req      in   1       exception/redirect request, level, sampled each cycle
//  flush_pc       in   32      redirect target, valid with flush_req
//  stall_o        out  6       [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = hold stage
//  flush_o        out  1       clear all pipeline registers (registered)
//  new_pc_o       out  32      redirect target for pc_reg, valid while flush_o=1 (registered)
//  ex_done_o      out  1       pulse: multi-cycle op completes, ex result valid
//  busy_o         out  1       state != RUN
//  stall_cnt_o    out  PERF_W  cycles with stall_o != 0, saturating
// BEHAVIOUR
//  Reset (async): state=RUN, cnt=0, stall_o=0, flush_o=0, new_pc_o=0, ex_done_o=0, stall_cnt_o=0.
//  States: RUN, EX_BUSY, FLUSH.
//  stall_o is combinational from registered state/cnt and current requests; flush_o, new_pc_o
//   and ex_done_o are registered.
//  Stall encodings: IF=6'b000011, ID=6'b000111, EX=6'b001111, none=6'b000000.
//  Priority, highest first: flush_req > EX (start or EX_BUSY) > ID > IF.
//  RUN:
//   flush_req=1 -> FLUSH next; flush_o=1 and new_pc_o=flush_pc next cycle; stall_o=0 now;
//    ex_start is dropped.
//   else ex_start=1 -> stall_o=EX now; cnt<=max(ex_len,1)-1; go to EX_BUSY.
//   else stall_o = ID if stallreq_id, else IF if stallreq_if, else 0.
//  EX_BUSY:
//   flush_req=1 -> abort op; cnt<=0; go to FLUSH; no ex_done_o.
//   cnt!=0 -> stall_o=EX, cnt<=cnt-1; stallreq_id/stallreq_if are masked (covered by EX).
//   cnt==0 -> stall_o=0; ex_done_o=1 next cycle; back to RUN.
//   ex_start while in EX_BUSY is ignored (protocol error, asserted in simulation).
//   Net effect: ex_len=N gives N stall cycles, then 1 release cycle.
//  FLUSH: lasts exactly 1 cycle; flush_o=1, stall_o=0, all requests ignored; then RUN.
//   flush_req held high re-enters FLUSH after one RUN cycle (no back-to-back flush).
//  stall_cnt_o increments by 1 on each cycle with stall_o!=0; holds at 2^PERF_W-1.
//  busy_o = (state!=RUN), combinational from state.
//  Reset asserted mid-op: everything returns to reset values immediately; no ex_done_o or
//   flush_o is emitted on release.
// STRUCTURE
//  Shared defines include (precompiled.v): `StallBus, the stall encodings above,
//   and state codes for RUN/EX_BUSY/FLUSH.
//  One sub-module: pipe_ctrl_perf (PERF_W saturating counter with inc/clear).
//  FSM + down-counter stay inline in pipe_ctrl.
// TESTING
//  1. Reset with all requests 0 -> stall_o=0, flush_o=0, stall_cnt_o=0.
//  2. stallreq_id=1 for 2 cycles -> stall_o=6'b000111 in both cycles; stall_cnt_o=2.
//  3. ex_start, ex_len=4 -> stall_o=6'b001111 for 4 cycles, 0 on the 5th;
//     ex_done_o=1 on the 6th; busy_o high on cycles 2-5.
//  4. ex_len=4 with flush_req, flush_pc=32'h0000_0100 in 2nd cycle -> next cycle flush_o=1,
//     new_pc_o=32'h100, stall_o=0; ex_done_o never pulses.
//  5. flush_req and ex_start in the same RUN cycle -> FLUSH taken, no EX stall.
//     stallreq_id+stallreq_if together -> 6'b000111.
//  6. Force stall_cnt_o to 2^PERF_W-2, stall 3 cycles -> holds at max.
//     rst pulse during EX_BUSY -> outputs zero asynchronously.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared stall encodings and sequencer state codes for the pipeline controller.
// Stall vector bit order: [0]pc [1]if [2]id [3]ex [4]mem [5]wb, 1 = hold that stage.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_IF   = 6'b000011;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_EX_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating stall-cycle counter; value visible one cycle after the counted cycle.
// No backpressure: inc is sampled every cycle, clear wins over inc.
module pipe_ctrl_perf #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              clear,
  output logic [PERF_W-1:0] cnt_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_o <= '0;
    end else if (clear) begin
      cnt_o <= '0;
    end else if (inc && (cnt_o != {PERF_W{1'b1}})) begin
      cnt_o <= cnt_o + PERF_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall_o combinational same cycle; flush_o/new_pc_o/ex_done_o one cycle late.
// Priority flush > multi-cycle EX > decode hazard > fetch wait; a flush aborts any EX op.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              ex_start,
  input  logic [CNT_W-1:0]  ex_len,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              ex_done_o,
  output logic              busy_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             flush_nxt, ex_done_nxt;
  logic [31:0]      new_pc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      cnt       <= '0;
      flush_o   <= 1'b0;
      new_pc_o  <= '0;
      ex_done_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      flush_o   <= flush_nxt;
      new_pc_o  <= new_pc_nxt;
      ex_done_o <= ex_done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    flush_nxt   = 1'b0;
    new_pc_nxt  = new_pc_o;
    ex_done_nxt = 1'b0;
    stall_o     = STALL_NONE;
    unique case (state)
      ST_RUN: begin
        if (flush_req) begin
          state_nxt  = ST_FLUSH;
          flush_nxt  = 1'b1;
          new_pc_nxt = flush_pc;
        end else if (ex_start) begin
          // Zero length still owns ex for one cycle.
          stall_o   = STALL_EX;
          cnt_nxt   = (ex_len == '0) ? '0 : ex_len - CNT_W'(1);
          state_nxt = ST_EX_BUSY;
        end else if (stallreq_id) begin
          stall_o = STALL_ID;
        end else if (stallreq_if) begin
          stall_o = STALL_IF;
        end
      end
      ST_EX_BUSY: begin
        if (flush_req) begin
          cnt_nxt    = '0;
          state_nxt  = ST_FLUSH;
          flush_nxt  = 1'b1;
          new_pc_nxt = flush_pc;
        end else if (cnt != '0) begin
          stall_o = STALL_EX;
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          ex_done_nxt = 1'b1;
          state_nxt   = ST_RUN;
        end
      end
      ST_FLUSH: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy_o = (state != ST_RUN);

  // A second ex_start while an op owns ex would be silently lost.
  assert property (@(posedge clk) disable iff (rst) !(state == ST_EX_BUSY && ex_start));

  pipe_ctrl_perf #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_o != STALL_NONE),
    .clear (1'b0),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic against an
// interval-based model (remaining EX ownership cycles, pending flush, pending done).
module tb_pipe_ctrl;

  localparam int CW = 6;
  localparam int PW = 8;
  localparam int CNT_MAX = (1 << PW) - 1;
  localparam logic [5:0] S_IF = 6'b000011;
  localparam logic [5:0] S_ID = 6'b000111;
  localparam logic [5:0] S_EX = 6'b001111;

  logic          clk = 1'b0;
  logic          rst;
  logic          stallreq_if, stallreq_id, ex_start, flush_req;
  logic [CW-1:0] ex_len;
  logic [31:0]   flush_pc;
  logic [5:0]    stall_o;
  logic          flush_o, ex_done_o, busy_o;
  logic [31:0]   new_pc_o;
  logic [PW-1:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;

  // model state: cycles the current EX op still owns ex (stalls + release cycle)
  int          m_own;
  bit          m_flush_now;
  bit          m_done_now;
  logic [31:0] m_pc;
  int          m_cnt;

  logic [5:0]  e_stall;
  bit          e_flush, e_done, e_busy;
  logic [31:0] e_pc;
  int          e_cnt;

  pipe_ctrl #(.CNT_W(CW), .PERF_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_if (stallreq_if),
    .stallreq_id (stallreq_id),
    .ex_start    (ex_start),
    .ex_len      (ex_len),
    .flush_req   (flush_req),
    .flush_pc    (flush_pc),
    .stall_o     (stall_o),
    .flush_o     (flush_o),
    .new_pc_o    (new_pc_o),
    .ex_done_o   (ex_done_o),
    .busy_o      (busy_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_own = 0; m_flush_now = 0; m_done_now = 0; m_pc = '0; m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    stallreq_if = 0; stallreq_id = 0; ex_start = 0; flush_req = 0; ex_len = '0; flush_pc = '0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle: sample registered outputs' expectations, drive inputs, settle, step model.
  task automatic cyc(input bit id, input bit ifr, input bit st, input logic [CW-1:0] len,
                     input bit fr, input logic [31:0] pc);
    @(negedge clk);
    e_flush = m_flush_now;
    e_pc    = m_pc;
    e_done  = m_done_now;
    e_busy  = m_flush_now || (m_own > 0);
    e_cnt   = m_cnt;
    stallreq_id = id; stallreq_if = ifr; ex_start = st; ex_len = len;
    flush_req = fr; flush_pc = pc;
    #1;
    m_done_now = 0;
    if (m_flush_now) begin
      e_stall = 6'b0; m_flush_now = 0;
    end else if (fr) begin
      e_stall = 6'b0; m_own = 0; m_flush_now = 1; m_pc = pc;
    end else if (m_own > 1) begin
      e_stall = S_EX; m_own = m_own - 1;
    end else if (m_own == 1) begin
      e_stall = 6'b0; m_own = 0; m_done_now = 1;
    end else if (st) begin
      e_stall = S_EX; m_own = (len == 0) ? 1 : int'(len);
    end else if (id) begin
      e_stall = S_ID;
    end else if (ifr) begin
      e_stall = S_IF;
    end else begin
      e_stall = 6'b0;
    end
    if (e_stall != 6'b0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    stallreq_if = 0; stallreq_id = 0; ex_start = 0; flush_req = 0; ex_len = '0; flush_pc = '0;
    model_clear();
    #1;
    total++; if (stall_o !== 6'b0) begin bad++; $display("FAIL reset_stall got=%b want=000000", stall_o); end
    total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", flush_o); end
    total++; if (stall_cnt_o !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt_o); end
    total++; if (busy_o !== 1'b0 || ex_done_o !== 1'b0 || new_pc_o !== 32'h0) begin
      bad++; $display("FAIL reset_misc got busy=%b done=%b pc=%h want 0/0/0", busy_o, ex_done_o, new_pc_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_id_stall();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      cyc(1, 0, 0, '0, 0, '0);
      total++; if (stall_o !== S_ID) begin bad++; $display("FAIL id_stall c%0d got=%b want=%b", c, stall_o, S_ID); end
    end
    cyc(0, 0, 0, '0, 0, '0);
    total++; if (stall_o !== 6'b0) begin bad++; $display("FAIL id_release got=%b want=000000", stall_o); end
    total++; if (stall_cnt_o !== PW'(2)) begin bad++; $display("FAIL id_cnt got=%0d want=2", stall_cnt_o); end
  endtask

  task automatic test_ex_op();
    logic [5:0] ws;
    do_reset();
    for (int c = 1; c <= 6; c++) begin
      cyc(0, 0, c == 1, CW'(4), 0, '0);
      ws = (c <= 4) ? S_EX : 6'b0;
      total++; if (stall_o !== ws) begin bad++; $display("FAIL ex_stall c%0d got=%b want=%b", c, stall_o, ws); end
      total++; if (busy_o !== (c >= 2 && c <= 5)) begin bad++; $display("FAIL ex_busy c%0d got=%b want=%b", c, busy_o, (c >= 2 && c <= 5)); end
      total++; if (ex_done_o !== (c == 6)) begin bad++; $display("FAIL ex_done c%0d got=%b want=%b", c, ex_done_o, (c == 6)); end
    end
  endtask

  task automatic test_flush_abort();
    do_reset();
    cyc(0, 0, 1, CW'(4), 0, '0);
    cyc(0, 0, 0, '0, 1, 32'h0000_0100);
    total++; if (stall_o !== 6'b0) begin bad++; $display("FAIL abort_stall got=%b want=000000", stall_o); end
    cyc(0, 0, 0, '0, 0, '0);
    total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL abort_flush got=%b want=1", flush_o); end
    total++; if (new_pc_o !== 32'h100) begin bad++; $display("FAIL abort_pc got=%h want=00000100", new_pc_o); end
    total++; if (stall_o !== 6'b0) begin bad++; $display("FAIL abort_flush_stall got=%b want=000000", stall_o); end
    for (int c = 0; c < 6; c++) begin
      cyc(0, 0, 0, '0, 0, '0);
      total++; if (ex_done_o !== 1'b0 || flush_o !== 1'b0) begin
        bad++; $display("FAIL abort_after c%0d got done=%b flush=%b want 0/0", c, ex_done_o, flush_o);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    cyc(0, 0, 1, CW'(5), 1, 32'hdead_beec);
    total++; if (stall_o !== 6'b0) begin bad++; $display("FAIL prio_flush_vs_ex got=%b want=000000", stall_o); end
    cyc(0, 0, 0, '0, 0, '0);
    total++; if (flush_o !== 1'b1 || new_pc_o !== 32'hdead_beec) begin
      bad++; $display("FAIL prio_flush_out got flush=%b pc=%h want 1/deadbeec", flush_o, new_pc_o);
    end
    cyc(0, 0, 0, '0, 0, '0);
    total++; if (busy_o !== 1'b0 || stall_o !== 6'b0 || ex_done_o !== 1'b0) begin
      bad++; $display("FAIL prio_ex_dropped got busy=%b stall=%b done=%b want 0/0/0", busy_o, stall_o, ex_done_o);
    end
    cyc(1, 1, 0, '0, 0, '0);
    total++; if (stall_o !== S_ID) begin bad++; $display("FAIL prio_id_if got=%b want=%b", stall_o, S_ID); end
    cyc(0, 1, 0, '0, 0, '0);
    total++; if (stall_o !== S_IF) begin bad++; $display("FAIL prio_if got=%b want=%b", stall_o, S_IF); end
    // held flush_req: FLUSH, RUN, FLUSH
    cyc(0, 0, 0, '0, 1, 32'h40);
    cyc(0, 0, 0, '0, 1, 32'h40);
    total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL held_flush1 got=%b want=1", flush_o); end
    cyc(1, 0, 0, '0, 1, 32'h40);
    total++; if (flush_o !== 1'b0 || stall_o !== 6'b0) begin
      bad++; $display("FAIL held_gap got flush=%b stall=%b want 0/000000", flush_o, stall_o);
    end
    cyc(0, 0, 0, '0, 0, '0);
    total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL held_flush2 got=%b want=1", flush_o); end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (254) cyc(0, 1, 0, '0, 0, '0);
    cyc(0, 1, 0, '0, 0, '0);
    total++; if (stall_cnt_o !== PW'(CNT_MAX - 1)) begin bad++; $display("FAIL sat_pre got=%0d want=%0d", stall_cnt_o, CNT_MAX - 1); end
    repeat (2) cyc(0, 1, 0, '0, 0, '0);
    cyc(0, 0, 0, '0, 0, '0);
    total++; if (stall_cnt_o !== PW'(CNT_MAX)) begin bad++; $display("FAIL sat_hold got=%0d want=%0d", stall_cnt_o, CNT_MAX); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    cyc(0, 0, 1, CW'(10), 0, '0);
    cyc(0, 0, 0, '0, 0, '0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if (stall_o !== 6'b0 || busy_o !== 1'b0 || stall_cnt_o !== '0) begin
      bad++; $display("FAIL midrst_async got stall=%b busy=%b cnt=%0d want 0/0/0", stall_o, busy_o, stall_cnt_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int c = 0; c < 12; c++) begin
      cyc(0, 0, 0, '0, 0, '0);
      total++; if (ex_done_o !== 1'b0 || flush_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++; $display("FAIL midrst_after c%0d got done=%b flush=%b busy=%b want 0/0/0", c, ex_done_o, flush_o, busy_o);
      end
    end
  endtask

  task automatic test_random();
    bit id, ifr, st, fr;
    logic [CW-1:0] len;
    logic [31:0] pc;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      id  = ($urandom_range(0, 3) == 0);
      ifr = ($urandom_range(0, 2) == 0);
      fr  = ($urandom_range(0, 11) == 0);
      st  = (m_own == 0) && ($urandom_range(0, 4) == 0);
      len = ($urandom_range(0, 5) == 0) ? CW'(0) : CW'($urandom_range(1, 7));
      pc  = $urandom;
      cyc(id, ifr, st, len, fr, pc);
      total++; if (stall_o !== e_stall) begin bad++; $display("FAIL rnd_stall c%0d got=%b want=%b", c, stall_o, e_stall); end
      total++; if (busy_o !== e_busy) begin bad++; $display("FAIL rnd_busy c%0d got=%b want=%b", c, busy_o, e_busy); end
      total++; if (flush_o !== e_flush) begin bad++; $display("FAIL rnd_flush c%0d got=%b want=%b", c, flush_o, e_flush); end
      total++; if (ex_done_o !== e_done) begin bad++; $display("FAIL rnd_done c%0d got=%b want=%b", c, ex_done_o, e_done); end
      total++; if (stall_cnt_o !== PW'(e_cnt)) begin bad++; $display("FAIL rnd_cnt c%0d got=%0d want=%0d", c, stall_cnt_o, e_cnt); end
      if (e_flush) begin
        total++; if (new_pc_o !== e_pc) begin bad++; $display("FAIL rnd_pc c%0d got=%h want=%h", c, new_pc_o, e_pc); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    stallreq_if = 0; stallreq_id = 0; ex_start = 0; flush_req = 0; ex_len = '0; flush_pc = '0;
    model_clear();
    test_reset();
    test_id_stall();
    test_ex_op();
    test_flush_abort();
    test_priority();
    test_saturate();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
